// File: rtl/oam_dma.sv
// Sprite DMA: snoops the cpu write to the trigger register, halts the cpu and
// copies one 256-byte page into the PPU OAM data port, one byte per read/write pair.
module oam_dma #(
    parameter logic [15:0] REG_ADDR      = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_write,
    input  logic [7:0]  bus_d_in,
    output logic        cpu_halt,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_d_out,
    output logic        dma_write
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t     state;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] latch;
    logic       par;
    logic       trig;

    assign trig = cpu_write && (cpu_addr == REG_ADDR);

    // Outputs are registered: each transition loads the values of the state it enters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            page       <= 8'h00;
            idx        <= 8'h00;
            latch      <= 8'h00;
            par        <= 1'b0;
            cpu_halt   <= 1'b0;
            dma_active <= 1'b0;
            dma_addr   <= 16'h0000;
            dma_d_out  <= 8'h00;
            dma_write  <= 1'b0;
        end else begin
            par       <= ~par;
            dma_write <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (trig) begin
                        page       <= cpu_d_out;
                        idx        <= 8'h00;
                        state      <= HALT;
                        cpu_halt   <= 1'b1;
                        dma_active <= 1'b1;
                    end
                end
                HALT: begin
                    // par is 1 now, so the following cycle is even: read directly.
                    if (par) begin
                        state    <= READ;
                        dma_addr <= {page, idx};
                    end else begin
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    state    <= READ;
                    dma_addr <= {page, idx};
                end
                READ: begin
                    latch     <= bus_d_in;
                    state     <= WRITE;
                    dma_addr  <= OAM_DATA_ADDR;
                    dma_d_out <= bus_d_in;
                    dma_write <= 1'b1;
                end
                WRITE: begin
                    dma_d_out <= 8'h00;
                    if (idx == LAST_IDX) begin
                        state      <= IDLE;
                        cpu_halt   <= 1'b0;
                        dma_active <= 1'b0;
                        dma_addr   <= 16'h0000;
                    end else begin
                        idx      <= idx + 8'd1;
                        state    <= READ;
                        dma_addr <= {page, idx + 8'd1};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: memory model on bus_d_in, scoreboard of expected OAM bytes.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_d_out = 8'h00;
    logic        cpu_write = 1'b0;
    logic [7:0]  bus_d_in;
    logic        cpu_halt;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic [7:0]  dma_d_out;
    logic        dma_write;

    int errors = 0;
    int checks = 0;

    logic [7:0]  q[$];
    int          halt_cnt = 0;
    int          wr_cnt = 0;
    logic        prev_wr = 1'b0;
    logic        rd_seen = 1'b0;
    logic [15:0] first_rd = 16'h0;
    logic [15:0] last_rd = 16'h0;
    logic        tb_par = 1'b0;

    oam_dma dut (
        .clk(clk),
        .rst(rst),
        .cpu_addr(cpu_addr),
        .cpu_d_out(cpu_d_out),
        .cpu_write(cpu_write),
        .bus_d_in(bus_d_in),
        .cpu_halt(cpu_halt),
        .dma_active(dma_active),
        .dma_addr(dma_addr),
        .dma_d_out(dma_d_out),
        .dma_write(dma_write)
    );

    always #5 clk = ~clk;

    // Memory: page 02 holds 00..FF, page 03 holds index^A5.
    function automatic logic [7:0] mem(input logic [15:0] a);
        if (a[15:8] == 8'h03) return a[7:0] ^ 8'hA5;
        return a[7:0];
    endfunction

    assign bus_d_in = mem(dma_addr);

    always @(posedge clk) tb_par <= rst ? 1'b0 : ~tb_par;

    always @(negedge clk) begin
        if (cpu_halt === 1'b1) halt_cnt++;
        if (dma_active === 1'b1 && dma_write === 1'b0 && dma_addr != 16'h0) begin
            if (!rd_seen) first_rd = dma_addr;
            rd_seen = 1'b1;
            last_rd = dma_addr;
        end
        if (dma_write === 1'b1) begin
            wr_cnt++;
            checks++;
            if (prev_wr) begin
                errors++;
                $display("FAIL back_to_back_write: got two consecutive dma_write, required none");
            end
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write",
                         dma_addr, dma_d_out);
            end else begin
                logic [7:0] exp;
                exp = q.pop_front();
                if (dma_addr !== 16'h2004 || dma_d_out !== exp) begin
                    errors++;
                    $display("FAIL oam_write: addr=%h data=%h, required addr=2004 data=%h",
                             dma_addr, dma_d_out, exp);
                end
            end
        end
        prev_wr = (dma_write === 1'b1);
    end

    task automatic push_page(input logic [7:0] p);
        for (int i = 0; i < 256; i++) q.push_back(mem({p, 8'(i)}));
    endtask

    task automatic clear_stats();
        halt_cnt = 0;
        wr_cnt = 0;
        rd_seen = 1'b0;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d, input logic want_par);
        @(negedge clk);
        while (tb_par !== want_par) @(negedge clk);
        cpu_addr = a;
        cpu_d_out = d;
        cpu_write = 1'b1;
        @(negedge clk);
        cpu_write = 1'b0;
        cpu_addr = 16'h0;
        cpu_d_out = 8'h0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (cpu_halt === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL %s_timeout: cpu_halt still 1 after %0d cycles, required fall", name, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_xfer(input string name, input int exp_halt,
                              input logic [15:0] exp_first, input logic [15:0] exp_last);
        checks++;
        if (halt_cnt != exp_halt) begin
            errors++;
            $display("FAIL %s_halt_len: got %0d cycles, required %0d", name, halt_cnt, exp_halt);
        end
        checks++;
        if (wr_cnt != 256 || q.size() != 0) begin
            errors++;
            $display("FAIL %s_writes: got %0d writes (%0d pending), required 256 (0)",
                     name, wr_cnt, q.size());
        end
        checks++;
        if (first_rd !== exp_first || last_rd !== exp_last) begin
            errors++;
            $display("FAIL %s_read_range: got %h..%h, required %h..%h",
                     name, first_rd, last_rd, exp_first, exp_last);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (cpu_halt !== 1'b0 || dma_active !== 1'b0 || dma_addr !== 16'h0 ||
            dma_d_out !== 8'h0 || dma_write !== 1'b0) begin
            errors++;
            $display("FAIL %s: halt=%b act=%b addr=%h d=%h wr=%b, required all 0",
                     name, cpu_halt, dma_active, dma_addr, dma_d_out, dma_write);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_idle_outputs("reset_outputs");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("after_reset_idle");
    endtask

    // Trigger with par==0 in the write cycle: HALT sees par==1, no ALIGN.
    task automatic test_no_align();
        clear_stats();
        push_page(8'h02);
        cpu_wr(16'h4014, 8'h02, 1'b0);
        wait_done("no_align");
        check_xfer("no_align", 513, 16'h0200, 16'h02FF);
    endtask

    task automatic test_align();
        clear_stats();
        push_page(8'h02);
        cpu_wr(16'h4014, 8'h02, 1'b1);
        wait_done("align");
        check_xfer("align", 514, 16'h0200, 16'h02FF);
    endtask

    task automatic test_retrigger();
        int n = 0;
        clear_stats();
        push_page(8'h02);
        cpu_wr(16'h4014, 8'h02, 1'b0);
        while (dma_addr !== 16'h0240 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        cpu_addr = 16'h4014;
        cpu_d_out = 8'h07;
        cpu_write = 1'b1;
        @(negedge clk);
        cpu_write = 1'b0;
        cpu_addr = 16'h0;
        cpu_d_out = 8'h0;
        wait_done("retrigger");
        check_xfer("retrigger", 513, 16'h0200, 16'h02FF);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int w;
        clear_stats();
        push_page(8'h02);
        cpu_wr(16'h4014, 8'h02, 1'b1);
        while (dma_addr !== 16'h0280 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_mid_outputs");
        q.delete();
        w = wr_cnt;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (wr_cnt != w || cpu_halt !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet: writes=%0d halt=%b, required writes=%0d halt=0",
                     wr_cnt, cpu_halt, w);
        end
        clear_stats();
        push_page(8'h03);
        cpu_wr(16'h4014, 8'h03, 1'b0);
        wait_done("page3");
        check_xfer("page3", 513, 16'h0300, 16'h03FF);
    endtask

    task automatic test_other_addr();
        clear_stats();
        cpu_wr(16'h4013, 8'h02, 1'b0);
        cpu_wr(16'h2004, 8'h02, 1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if (halt_cnt != 0 || wr_cnt != 0) begin
            errors++;
            $display("FAIL other_addr: halt_cycles=%0d writes=%0d, required 0 and 0",
                     halt_cnt, wr_cnt);
        end
        check_idle_outputs("other_addr_outputs");
    endtask

    initial begin
        test_reset();
        test_no_align();
        test_align();
        test_retrigger();
        test_reset_mid();
        test_other_addr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
